// File: rtl/prog_loader.sv
// Byte-serial boot loader: parses a header/word/checksum frame, writes words
// into program memory and releases the core only after the checksum verifies.
module prog_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              reload,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_rstn,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = 7;
  localparam logic [CNT_W-1:0] DEPTH_L = CNT_W'(DEPTH);

  typedef enum logic [2:0] {S_HDR, S_HI, S_LO, S_CSUM, S_DONE, S_ERR} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    n_words, n_words_nxt;
  logic [ADDR_W-1:0]   idx, idx_nxt;
  logic [7:0]          csum, csum_nxt;
  logic [7:0]          hi_byte, hi_byte_nxt;
  logic                mem_we_nxt;
  logic [ADDR_W-1:0]   mem_addr_nxt;
  logic [WORD_W-1:0]   mem_wdata_nxt;
  logic                accept;
  logic                hdr_ok;
  logic                last_word;

  assign accept    = byte_valid && byte_ready;
  assign hdr_ok    = (byte_data[7:6] == 2'b00) && (byte_data[5:0] != 6'd0) &&
                     ({1'b0, byte_data[5:0]} <= DEPTH_L);
  assign last_word = (CNT_W'(idx) + CNT_W'(1)) == n_words;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_HDR;
      n_words    <= '0;
      idx        <= '0;
      csum       <= '0;
      hi_byte    <= '0;
      byte_ready <= 1'b1;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rstn   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      n_words    <= n_words_nxt;
      idx        <= idx_nxt;
      csum       <= csum_nxt;
      hi_byte    <= hi_byte_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      // Status outputs are pure decodes of the next state, registered.
      byte_ready <= (state_nxt != S_DONE) && (state_nxt != S_ERR);
      cpu_rstn   <= (state_nxt == S_DONE);
      done       <= (state_nxt == S_DONE);
      err        <= (state_nxt == S_ERR);
    end
  end

  always_comb begin
    state_nxt     = state;
    n_words_nxt   = n_words;
    idx_nxt       = idx;
    csum_nxt      = csum;
    hi_byte_nxt   = hi_byte;
    mem_we_nxt    = 1'b0;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;

    if (reload) begin
      // Restart wins over any byte on the same edge; write bus holds.
      state_nxt   = S_HDR;
      n_words_nxt = '0;
      idx_nxt     = '0;
      csum_nxt    = '0;
      hi_byte_nxt = '0;
    end else if (accept) begin
      unique case (state)
        S_HDR: begin
          n_words_nxt = {1'b0, byte_data[5:0]};
          csum_nxt    = byte_data;
          state_nxt   = hdr_ok ? S_HI : S_ERR;
        end
        S_HI: begin
          hi_byte_nxt = byte_data;
          csum_nxt    = csum ^ byte_data;
          state_nxt   = S_LO;
        end
        S_LO: begin
          csum_nxt      = csum ^ byte_data;
          mem_we_nxt    = 1'b1;
          mem_addr_nxt  = idx;
          mem_wdata_nxt = WORD_W'({hi_byte, byte_data});
          if (last_word) begin
            idx_nxt   = '0;
            state_nxt = S_CSUM;
          end else begin
            idx_nxt   = idx + ADDR_W'(1);
            state_nxt = S_HI;
          end
        end
        S_CSUM: begin
          state_nxt = (byte_data == csum) ? S_DONE : S_ERR;
        end
        default: begin
          state_nxt = state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames images byte by byte and checks
// memory writes, status outputs, reload and asynchronous reset behaviour.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        reload = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_rstn;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  logic [4:0]  wr_addr [$];
  logic [15:0] wr_data [$];
  int          wr_cyc  [$];
  logic [7:0]  img     [$];

  prog_loader #(.DEPTH(32), .ADDR_W(5), .WORD_W(16)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .reload    (reload),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rstn  (cpu_rstn),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rstn && mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      wr_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("byte_ready_wait", byte_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_gap(input logic [7:0] b);
    @(negedge clk);
    byte_valid = 1'b0;
    byte_data  = 8'($urandom);
    repeat (2) begin
      @(negedge clk);
      byte_data = 8'($urandom);
    end
    send_byte(b);
  endtask

  task automatic send_img(input bit gapped);
    foreach (img[i]) begin
      if (gapped) send_gap(img[i]);
      else        send_byte(img[i]);
    end
  endtask

  task automatic do_reload();
    @(negedge clk);
    byte_valid = 1'b0;
    reload     = 1'b1;
    @(negedge clk);
    reload     = 1'b0;
  endtask

  task automatic check_five(input string t);
    logic [15:0] exp_w [5];
    exp_w = '{16'h0A02, 16'h4B00, 16'h4505, 16'h4B00, 16'h0C04};
    check({t, "_nwrites"}, wr_addr.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < wr_addr.size()) begin
        check({t, "_addr"}, wr_addr[i], i);
        check({t, "_data"}, wr_data[i], exp_w[i]);
      end
    end
    check({t, "_done"}, done, 1'b1);
    check({t, "_err"}, err, 1'b0);
    check({t, "_cpu_rstn"}, cpu_rstn, 1'b1);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_ready", byte_ready, 1'b1);
    check("rst_we", mem_we, 1'b0);
    check("rst_cpu_rstn", cpu_rstn, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_addr", mem_addr, 5'd0);
    check("rst_wdata", mem_wdata, 16'h0000);
    @(negedge clk);
    rstn = 1'b1;

    // Test 1: single-word image, valid held high
    clear_log();
    img = '{8'h01, 8'h0A, 8'h02};
    send_img(1'b0);
    check("t1_cpu_rstn_pre", cpu_rstn, 1'b0);
    check("t1_done_pre", done, 1'b0);
    send_byte(8'h09);
    check("t1_done", done, 1'b1);
    check("t1_cpu_rstn", cpu_rstn, 1'b1);
    check("t1_ready", byte_ready, 1'b0);
    byte_data = 8'h5A;
    repeat (3) @(negedge clk);
    check("t1_nwrites", wr_addr.size(), 1);
    if (wr_addr.size() > 0) begin
      check("t1_addr", wr_addr[0], 5'd0);
      check("t1_data", wr_data[0], 16'h0A02);
    end
    check("t1_done_sticky", done, 1'b1);

    // Test 2: five-word image at full rate
    do_reload();
    check("t2_reload_done", done, 1'b0);
    check("t2_reload_cpu", cpu_rstn, 1'b0);
    check("t2_reload_ready", byte_ready, 1'b1);
    clear_log();
    img = '{8'h05, 8'h0A, 8'h02, 8'h4B, 8'h00, 8'h45, 8'h05, 8'h4B, 8'h00, 8'h0C, 8'h04, 8'h45};
    send_img(1'b0);
    repeat (2) @(negedge clk);
    check_five("t2");
    for (int i = 1; i < wr_cyc.size(); i++)
      check("t2_spacing", wr_cyc[i] - wr_cyc[i-1], 2);

    // Test 3: bad headers
    do_reload();
    clear_log();
    send_byte(8'h00);
    check("t3_err_n0", err, 1'b1);
    check("t3_ready_n0", byte_ready, 1'b0);
    do_reload();
    check("t3_err_cleared", err, 1'b0);
    send_byte(8'h21);
    check("t3_err_n33", err, 1'b1);
    do_reload();
    send_byte(8'h41);
    check("t3_err_hibits", err, 1'b1);
    check("t3_cpu_rstn", cpu_rstn, 1'b0);
    check("t3_done", done, 1'b0);
    repeat (2) @(negedge clk);
    check("t3_nwrites", wr_addr.size(), 0);

    // Test 4: bad checksum
    do_reload();
    clear_log();
    img = '{8'h01, 8'h12, 8'h34, 8'h00};
    send_img(1'b0);
    check("t4_err", err, 1'b1);
    check("t4_done", done, 1'b0);
    check("t4_cpu_rstn", cpu_rstn, 1'b0);
    check("t4_nwrites", wr_addr.size(), 1);
    if (wr_addr.size() > 0) begin
      check("t4_addr", wr_addr[0], 5'd0);
      check("t4_data", wr_data[0], 16'h1234);
    end

    // Test 5: five-word image with gaps in valid
    do_reload();
    clear_log();
    img = '{8'h05, 8'h0A, 8'h02, 8'h4B, 8'h00, 8'h45, 8'h05, 8'h4B, 8'h00, 8'h0C, 8'h04, 8'h45};
    send_img(1'b1);
    repeat (2) @(negedge clk);
    check_five("t5");

    // Test 6a: reload mid-image, byte on the reload edge is dropped
    do_reload();
    clear_log();
    img = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_img(1'b0);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = 8'h66;
    reload     = 1'b1;
    @(negedge clk);
    reload     = 1'b0;
    byte_valid = 1'b0;
    check("t6a_ready", byte_ready, 1'b1);
    check("t6a_err", err, 1'b0);
    check("t6a_addr_hold", mem_addr, 5'd1);
    check("t6a_wdata_hold", mem_wdata, 16'h3344);
    check("t6a_nwrites_mid", wr_addr.size(), 2);
    img = '{8'h01, 8'h77, 8'h88, 8'hFE};
    send_img(1'b0);
    repeat (2) @(negedge clk);
    check("t6a_nwrites", wr_addr.size(), 3);
    if (wr_addr.size() == 3) begin
      check("t6a_addr", wr_addr[2], 5'd0);
      check("t6a_data", wr_data[2], 16'h7788);
    end
    check("t6a_done", done, 1'b1);

    // Test 6b: asynchronous reset mid-image
    do_reload();
    img = '{8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    send_img(1'b0);
    check("t6b_addr_pre", mem_addr, 5'd1);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("t6b_ready", byte_ready, 1'b1);
    check("t6b_we", mem_we, 1'b0);
    check("t6b_addr", mem_addr, 5'd0);
    check("t6b_wdata", mem_wdata, 16'h0000);
    check("t6b_cpu_rstn", cpu_rstn, 1'b0);
    check("t6b_done", done, 1'b0);
    check("t6b_err", err, 1'b0);
    @(negedge clk);
    byte_valid = 1'b0;
    rstn = 1'b1;
    clear_log();
    img = '{8'h01, 8'h0A, 8'h02, 8'h09};
    send_img(1'b0);
    check("t6b_reload_done", done, 1'b1);
    repeat (2) @(negedge clk);
    check("t6b_nwrites", wr_addr.size(), 1);
    if (wr_addr.size() > 0) check("t6b_addr0", wr_addr[0], 5'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
